// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM port arbiter.
package sram_port_arbiter_pkg;

  // Geometry of the image-buffer SRAM, same values as the procedure cores use.
  localparam int SRAM_A_WIDTH = 17;
  localparam int SRAM_D_WIDTH = 8;

  // Port ownership. The value 2'd3 is unreachable and recovers to NONE.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Access direction as carried on RWk and M_RW.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Ownership state belonging to requester id.
  function automatic arb_state_e own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rd_tag_pipe.sv
// RD_LAT-stage delay line for {valid, requester id} of issued reads, so that
// the returning SRAM data can be steered to the requester that asked for it.
module sram_port_arbiter_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic in_vld,
  input  logic in_id,
  output logic out_vld,
  output logic out_id,
  output logic any_vld
);

  logic [RD_LAT-1:0] vld_reg;
  logic [RD_LAT-1:0] id_reg;

  // Shift the tag one stage per cycle; reset drops every read still in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_reg <= '0;
      id_reg  <= '0;
    end else begin
      vld_reg[0] <= in_vld;
      id_reg[0]  <= in_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        id_reg[i]  <= id_reg[i-1];
      end
    end
  end

  assign out_vld = vld_reg[RD_LAT-1];
  assign out_id  = id_reg[RD_LAT-1];
  assign any_vld = |vld_reg;

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin owner of a single-port SRAM shared by two requesters, with a
// burst limit, a per-owner lock against preemption, and tagged read return.
module sram_port_arbiter #(
  parameter int A_WIDTH   = sram_port_arbiter_pkg::SRAM_A_WIDTH,
  parameter int D_WIDTH   = sram_port_arbiter_pkg::SRAM_D_WIDTH,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Req0,
  input  logic               Req1,
  input  logic               Lock0,
  input  logic               Lock1,
  input  logic               RW0,
  input  logic               RW1,
  input  logic [A_WIDTH-1:0] Addr0,
  input  logic [A_WIDTH-1:0] Addr1,
  input  logic [D_WIDTH-1:0] Wd0,
  input  logic [D_WIDTH-1:0] Wd1,
  output logic               Gnt0,
  output logic               Gnt1,
  output logic               Rvld0,
  output logic               Rvld1,
  output logic [D_WIDTH-1:0] Rd,
  output logic [A_WIDTH-1:0] M_Addr,
  output logic [D_WIDTH-1:0] M_Di,
  input  logic [D_WIDTH-1:0] M_Do,
  output logic               M_RW,
  output logic               M_En,
  output logic               Busy
);
  import sram_port_arbiter_pkg::*;

  localparam int             CW      = $clog2(MAX_BURST);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

  arb_state_e         state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               ptr_reg, ptr_next;
  logic [A_WIDTH-1:0] addr_hold_reg;
  logic [D_WIDTH-1:0] di_hold_reg;

  logic               own_id;
  logic               own_req;
  logic               other_req;
  logic               own_lock;
  logic               acc;
  logic               sel_rw;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wd;
  logic               pipe_vld;
  logic               pipe_id;
  logic               pipe_any;

  // Select the current owner's request, lock and access fields.
  always_comb begin
    own_id    = (state_reg == OWN1);
    own_req   = own_id ? Req1  : Req0;
    other_req = own_id ? Req0  : Req1;
    own_lock  = own_id ? Lock1 : Lock0;
    sel_rw    = own_id ? RW1   : RW0;
    sel_addr  = own_id ? Addr1 : Addr0;
    sel_wd    = own_id ? Wd1   : Wd0;
    // Only a legal ownership state together with its own request is an access.
    acc       = ((state_reg == OWN0) & Req0) | ((state_reg == OWN1) & Req1);
  end

  // Ownership, burst counter and priority pointer for the next cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      NONE: begin
        cnt_next = '0;
        if (Req0 & Req1) state_next = own_state(ptr_reg);
        else if (Req0)   state_next = OWN0;
        else if (Req1)   state_next = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          // Owner released: hand straight over, or go idle.
          state_next = other_req ? own_state(!own_id) : NONE;
          cnt_next   = '0;
          ptr_next   = !own_id;
        end else if ((cnt_reg == CNT_MAX) && other_req && !own_lock) begin
          // Burst limit reached while the peer waits: this access is the last.
          state_next = own_state(!own_id);
          cnt_next   = '0;
          ptr_next   = !own_id;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = NONE;
        cnt_next   = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= NONE;
      cnt_reg   <= '0;
      ptr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Remember the last address and write data so the bus holds between accesses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      addr_hold_reg <= '0;
      di_hold_reg   <= '0;
    end else if (acc) begin
      addr_hold_reg <= sel_addr;
      di_hold_reg   <= sel_wd;
    end
  end

  sram_port_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .Clk     (Clk),
    .Rst     (Rst),
    .in_vld  (acc & (sel_rw == RW_READ)),
    .in_id   (own_id),
    .out_vld (pipe_vld),
    .out_id  (pipe_id),
    .any_vld (pipe_any)
  );

  assign Gnt0   = (state_reg == OWN0);
  assign Gnt1   = (state_reg == OWN1);
  assign M_En   = acc;
  assign M_RW   = acc & sel_rw;
  assign M_Addr = acc ? sel_addr : addr_hold_reg;
  assign M_Di   = acc ? sel_wd   : di_hold_reg;
  assign Rvld0  = pipe_vld & !pipe_id;
  assign Rvld1  = pipe_vld &  pipe_id;
  assign Rd     = M_Do;
  assign Busy   = (state_reg != NONE) | pipe_any;

endmodule
